// File: rtl/front_pipe_ctrl.sv
// Front-end pipeline control for the RV32I core: PC, IF/ID and ID/EX registers
// with stall, bubble and redirect sequencing, plus a saturating stall counter.
module front_pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall_pc,
  input  logic              i_stall_if_id,
  input  logic              i_bubble_id_ex,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_imem_valid,
  output logic [31:0]       o_pc,
  output logic              o_if_id_valid,
  output logic [31:0]       o_if_id_pc,
  output logic [31:0]       o_if_id_instr,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic [31:0]       i_id_rs1_data,
  input  logic [31:0]       i_id_rs2_data,
  input  logic [31:0]       i_id_imm,
  input  logic [4:0]        i_id_rd,
  output logic              o_id_ex_valid,
  output logic [31:0]       o_id_ex_pc,
  output logic [CTRL_W-1:0] o_id_ex_ctrl,
  output logic [31:0]       o_id_ex_rs1_data,
  output logic [31:0]       o_id_ex_rs2_data,
  output logic [31:0]       o_id_ex_imm,
  output logic [4:0]        o_id_ex_rd,
  output logic [31:0]       o_stall_cycles
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q;
  logic [31:0] stall_cnt;
  logic        redir;
  logic        stall_evt;

  // A stalled or empty ID slot cannot redirect; the branch re-asserts once it moves.
  assign redir     = i_redirect & o_if_id_valid & ~i_stall_if_id;
  assign stall_evt = (i_stall_pc | ~i_imem_valid) & ~redir;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q <= RESET_PC & ALIGN_MASK;
    end else if (redir) begin
      pc_q <= i_redirect_pc & ALIGN_MASK;
    end else if (!i_stall_pc && i_imem_valid) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  assign o_pc = pc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_if_id_valid <= 1'b0;
      o_if_id_pc    <= 32'h0;
      o_if_id_instr <= NOP_INSTR;
    end else if (i_stall_if_id) begin
      o_if_id_valid <= o_if_id_valid;
    end else if (redir || !i_imem_valid) begin
      o_if_id_valid <= 1'b0;
      o_if_id_instr <= NOP_INSTR;
    end else begin
      o_if_id_valid <= 1'b1;
      o_if_id_pc    <= pc_q;
      o_if_id_instr <= i_imem_rdata;
    end
  end

  // The redirecting instruction still advances so JAL/JALR can write the link.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_bubble_id_ex || !o_if_id_valid) begin
      o_id_ex_valid    <= 1'b0;
      o_id_ex_pc       <= 32'h0;
      o_id_ex_ctrl     <= '0;
      o_id_ex_rs1_data <= 32'h0;
      o_id_ex_rs2_data <= 32'h0;
      o_id_ex_imm      <= 32'h0;
      o_id_ex_rd       <= 5'd0;
    end else begin
      o_id_ex_valid    <= 1'b1;
      o_id_ex_pc       <= o_if_id_pc;
      o_id_ex_ctrl     <= i_id_ctrl;
      o_id_ex_rs1_data <= i_id_rs1_data;
      o_id_ex_rs2_data <= i_id_rs2_data;
      o_id_ex_imm      <= i_id_imm;
      o_id_ex_rd       <= i_id_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= 32'h0;
    end else if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cnt;

endmodule

// File: tb/tb_front_pipe_ctrl.sv
// Directed bench for front_pipe_ctrl: fetch, stall, redirect, imem-invalid,
// counter saturation and reset-override sequences with hand-computed results.
module tb_front_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall_pc, stall_if_id, bubble_id_ex, redirect, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic [31:0] pc, if_id_pc, if_id_instr, id_ex_pc, id_ex_ctrl;
  logic [31:0] id_ex_rs1, id_ex_rs2, id_ex_imm, stall_cycles;
  logic [31:0] id_ctrl, id_rs1, id_rs2, id_imm;
  logic [4:0]  id_rd, id_ex_rd;
  logic        if_id_valid, id_ex_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory and decode stand-ins: values are simple functions of the address.
  assign imem_rdata = pc + 32'h0100_0000;
  assign id_ctrl    = if_id_pc ^ 32'hC0DE_0000;
  assign id_rs1     = if_id_pc + 32'd1;
  assign id_rs2     = if_id_pc + 32'd2;
  assign id_imm     = if_id_pc + 32'd3;
  assign id_rd      = if_id_pc[6:2];

  front_pipe_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_stall_pc(stall_pc), .i_stall_if_id(stall_if_id), .i_bubble_id_ex(bubble_id_ex),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .i_imem_rdata(imem_rdata), .i_imem_valid(imem_valid),
    .o_pc(pc), .o_if_id_valid(if_id_valid), .o_if_id_pc(if_id_pc), .o_if_id_instr(if_id_instr),
    .i_id_ctrl(id_ctrl), .i_id_rs1_data(id_rs1), .i_id_rs2_data(id_rs2),
    .i_id_imm(id_imm), .i_id_rd(id_rd),
    .o_id_ex_valid(id_ex_valid), .o_id_ex_pc(id_ex_pc), .o_id_ex_ctrl(id_ex_ctrl),
    .o_id_ex_rs1_data(id_ex_rs1), .o_id_ex_rs2_data(id_ex_rs2),
    .o_id_ex_imm(id_ex_imm), .o_id_ex_rd(id_ex_rd),
    .o_stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_front(input string tag, input logic [31:0] e_pc,
                             input logic e_ifv, input logic [31:0] e_ifpc,
                             input logic [31:0] e_instr);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".if_v"}, {31'h0, if_id_valid}, {31'h0, e_ifv});
    check({tag, ".if_pc"}, if_id_pc, e_ifpc);
    check({tag, ".if_instr"}, if_id_instr, e_instr);
  endtask

  task automatic check_ex(input string tag, input logic e_v, input logic [31:0] e_pc);
    check({tag, ".ex_v"}, {31'h0, id_ex_valid}, {31'h0, e_v});
    check({tag, ".ex_pc"}, id_ex_pc, e_pc);
  endtask

  initial begin
    rst = 1'b1; stall_pc = 1'b0; stall_if_id = 1'b0; bubble_id_ex = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; imem_valid = 1'b1;
    step(); step();
    check_front("rst", 32'h0, 1'b0, 32'h0, 32'h13);
    check_ex("rst", 1'b0, 32'h0);
    check("rst.cnt", stall_cycles, 32'h0);
    rst = 1'b0;

    step();
    check_front("f1", 32'h4, 1'b1, 32'h0, 32'h0100_0000);
    check_ex("f1", 1'b0, 32'h0);
    step();
    check_front("f2", 32'h8, 1'b1, 32'h4, 32'h0100_0004);
    check_ex("f2", 1'b1, 32'h0);
    step();
    check_front("f3", 32'hC, 1'b1, 32'h8, 32'h0100_0008);
    check_ex("f3", 1'b1, 32'h4);
    check("f3.ctrl", id_ex_ctrl, 32'hC0DE_0004);
    check("f3.rs1", id_ex_rs1, 32'h5);
    check("f3.rs2", id_ex_rs2, 32'h6);
    check("f3.imm", id_ex_imm, 32'h7);
    check("f3.rd", {27'h0, id_ex_rd}, 32'h1);

    // load-use stall: all three together for one cycle
    stall_pc = 1'b1; stall_if_id = 1'b1; bubble_id_ex = 1'b1;
    step();
    check_front("st", 32'hC, 1'b1, 32'h8, 32'h0100_0008);
    check_ex("st", 1'b0, 32'h0);
    check("st.ctrl", id_ex_ctrl, 32'h0);
    check("st.cnt", stall_cycles, 32'h1);
    stall_pc = 1'b0; stall_if_id = 1'b0; bubble_id_ex = 1'b0;
    step();
    check_front("st2", 32'h10, 1'b1, 32'hC, 32'h0100_000C);
    check_ex("st2", 1'b1, 32'h8);

    // redirect with unaligned target
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    check_front("rd", 32'h100, 1'b0, 32'hC, 32'h13);
    check_ex("rd", 1'b1, 32'hC);
    check("rd.ctrl", id_ex_ctrl, 32'hC0DE_000C);
    check("rd.rd", {27'h0, id_ex_rd}, 32'h3);
    check("rd.cnt", stall_cycles, 32'h1);
    redirect = 1'b0;
    step();
    check_front("rd1", 32'h104, 1'b1, 32'h100, 32'h0100_0100);
    check_ex("rd1", 1'b0, 32'h0);
    step();
    check_front("rd2", 32'h108, 1'b1, 32'h104, 32'h0100_0104);
    check_ex("rd2", 1'b1, 32'h100);

    // redirect while stalled is ignored, then taken
    redirect = 1'b1; redirect_pc = 32'h20;
    stall_pc = 1'b1; stall_if_id = 1'b1; bubble_id_ex = 1'b1;
    step();
    check_front("rs", 32'h108, 1'b1, 32'h104, 32'h0100_0104);
    check_ex("rs", 1'b0, 32'h0);
    check("rs.cnt", stall_cycles, 32'h2);
    stall_pc = 1'b0; stall_if_id = 1'b0; bubble_id_ex = 1'b0;
    step();
    check_front("rs2", 32'h20, 1'b0, 32'h104, 32'h13);
    check_ex("rs2", 1'b1, 32'h104);
    check("rs2.cnt", stall_cycles, 32'h2);
    redirect = 1'b0;

    // instruction memory not ready for three cycles
    imem_valid = 1'b0;
    step();
    check_front("iv1", 32'h20, 1'b0, 32'h104, 32'h13);
    check_ex("iv1", 1'b0, 32'h0);
    step(); step();
    check_front("iv3", 32'h20, 1'b0, 32'h104, 32'h13);
    check("iv3.cnt", stall_cycles, 32'h5);
    imem_valid = 1'b1;
    step();
    check_front("iv4", 32'h24, 1'b1, 32'h20, 32'h0100_0020);
    check("iv4.cnt", stall_cycles, 32'h5);

    // counter saturation, using stall_pc alone (IF/ID keeps loading)
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    stall_pc = 1'b1;
    step();
    check("sat1.cnt", stall_cycles, 32'hFFFF_FFFF);
    check_front("sat1", 32'h24, 1'b1, 32'h24, 32'h0100_0024);
    step();
    check("sat2.cnt", stall_cycles, 32'hFFFF_FFFF);

    // reset overrides an active stall and redirect
    stall_if_id = 1'b1; bubble_id_ex = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h400; imem_valid = 1'b0;
    rst = 1'b1;
    step();
    check_front("rr", 32'h0, 1'b0, 32'h0, 32'h13);
    check_ex("rr", 1'b0, 32'h0);
    check("rr.ctrl", id_ex_ctrl, 32'h0);
    check("rr.rs1", id_ex_rs1, 32'h0);
    check("rr.rs2", id_ex_rs2, 32'h0);
    check("rr.imm", id_ex_imm, 32'h0);
    check("rr.rd", {27'h0, id_ex_rd}, 32'h0);
    check("rr.cnt", stall_cycles, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/front_pipe_ctrl.md
Name: front_pipe_ctrl

Overview:
Owns the PC register, the IF/ID pipeline register and the ID/EX pipeline register of the RV32I core. It consumes the stall/bubble requests produced by hazard detection, the ID-stage branch/jump redirect and the instruction-memory valid handshake. It sequences fetch, hold, flush and bubble insertion accordingly. It also keeps a saturating stall-cycle performance counter.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
CTRL_W, 32, width of the ID-stage decoded control bundle carried into ID/EX
NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on flush or bubble (addi x0,x0,0)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_stall_pc  in  1  hold PC this cycle
i_stall_if_id  in  1  hold IF/ID this cycle
i_bubble_id_ex  in  1  load a bubble into ID/EX this cycle
i_redirect  in  1  ID-stage branch taken / JAL / JALR resolved this cycle
i_redirect_pc  in  32  redirect target
i_imem_rdata  in  32  instruction at o_pc (combinational read, same cycle)
i_imem_valid  in  1  i_imem_rdata is valid this cycle
o_pc  out  32  current fetch address
o_if_id_valid  out  1  IF/ID holds a real instruction
o_if_id_pc  out  32  PC of IF/ID instruction
o_if_id_instr  out  32  IF/ID instruction word
i_id_ctrl  in  CTRL_W  decoded control for IF/ID instruction
i_id_rs1_data  in  32  rs1 operand
i_id_rs2_data  in  32  rs2 operand
i_id_imm  in  32  immediate
i_id_rd  in  5  destination register
o_id_ex_valid  out  1  ID/EX holds a real instruction
o_id_ex_pc  out  32  ID/EX PC
o_id_ex_ctrl  out  CTRL_W  ID/EX control bundle
o_id_ex_rs1_data  out  32  ID/EX rs1 operand
o_id_ex_rs2_data  out  32  ID/EX rs2 operand
o_id_ex_imm  out  32  ID/EX immediate
o_id_ex_rd  out  5  ID/EX destination register
o_stall_cycles  out  32  saturating count of stalled fetch cycles

Behaviour:
- Reset (i_rst=1 at edge), overriding all other inputs including mid-stall or mid-redirect: o_pc=RESET_PC; o_if_id_valid=0, o_if_id_pc=0, o_if_id_instr=NOP_INSTR; o_id_ex_valid=0, ctrl/rs1/rs2/imm/pc=0, rd=0; o_stall_cycles=0.
- Effective redirect: redir = i_redirect & o_if_id_valid & ~i_stall_if_id. A redirect raised by a stalled or invalid ID instruction is ignored; the stalled branch re-asserts it next cycle.
- PC next-state, in priority order:
  - redir -> {i_redirect_pc[31:2],2'b00}.
  - Else i_stall_pc -> hold.
  - Else ~i_imem_valid -> hold.
  - Else o_pc+4, wrapping modulo 2^32.
  - o_pc[1:0] is always 00.
- IF/ID next-state, in priority order:
  - i_stall_if_id -> hold all fields.
  - Else redir -> flush: valid=0, instr=NOP_INSTR, pc unchanged.
  - Else ~i_imem_valid -> bubble: valid=0, instr=NOP_INSTR.
  - Else load {valid=1, pc=o_pc, instr=i_imem_rdata}.
- ID/EX next-state:
  - If i_bubble_id_ex or ~o_if_id_valid -> bubble: valid=0, ctrl=0, rd=0; data fields don't-care, implemented as 0.
  - Else load all i_id_* and o_if_id_pc, valid=1.
  - The redirecting instruction itself advances into ID/EX (JAL/JALR need the link writeback).
- Independent inputs: i_stall_pc, i_stall_if_id and i_bubble_id_ex are each honoured as specified even if asserted singly. Normal use asserts all three together.
- Latency:
  - Fetched word appears in IF/ID 1 cycle after fetch and in ID/EX 2 cycles after fetch.
  - A redirect costs exactly 1 bubble: the wrong-path fetch is flushed, and the target is fetched the cycle after redirect.
  - A load-use stall costs exactly 1 bubble in ID/EX.
- o_stall_cycles increments by 1 in each non-reset cycle where (i_stall_pc | ~i_imem_valid) & ~redir. It saturates at 32'hFFFF_FFFF and never wraps.

Test Plan:
- Reset then 4 cycles of i_imem_valid=1 -> o_pc sequence 0,4,8,C,10; IF/ID pc follows one cycle later; o_id_ex_valid first 1 in cycle 3.
- Stall all three for one cycle, IF/ID pc=8 -> o_pc holds at 0xC; IF/ID holds pc=8 for 2 cycles; ID/EX valid=0 for exactly one cycle; o_stall_cycles=1.
- i_redirect=1, target 0x103 with IF/ID valid -> next o_pc=0x100; IF/ID valid=0 with instr=0x00000013; branch instr enters ID/EX with valid=1.
- i_redirect=1 together with i_stall_if_id=1 -> redirect ignored; PC and IF/ID hold. Next cycle, stall low with redirect -> redirect taken.
- i_imem_valid=0 for 3 cycles at o_pc=0x20 -> PC holds at 0x20; 3 IF/ID bubbles; o_stall_cycles +3. Preload counter to 32'hFFFF_FFFE via long stall -> counter saturates at 32'hFFFF_FFFF.
- Assert i_rst during an active stall and redirect -> all outputs at reset values next cycle; o_pc=RESET_PC.
